// File: rtl/bm_pack_if.sv
// rtl/bm_pack_if.sv - byte-in / word-out handshake bundle for bm_pack
interface bm_pack_if #(
  parameter int FIFO_AW = 4
);
  logic [7:0]         byte_data;
  logic               byte_vld;
  logic [31:0]        word_q;
  logic               word_vld;
  logic               word_req;
  logic [FIFO_AW:0]   word_cnt;
  logic               full;
  logic [7:0]         ovf_cnt;

  modport master (
    output byte_data, byte_vld, word_req,
    input  word_q, word_vld, word_cnt, full, ovf_cnt
  );

  modport slave (
    input  byte_data, byte_vld, word_req,
    output word_q, word_vld, word_cnt, full, ovf_cnt
  );
endinterface

// File: rtl/bm_pack.sv
// rtl/bm_pack.sv - big-endian byte-to-word packer feeding a show-ahead word FIFO
// Optional idle-timeout flush of partial words: BM_PACK_TIMEOUT_FLUSH_EN.
module bm_pack #(
  parameter int FIFO_AW = 4,
  parameter int TIMEOUT = 255
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       clr,
  bm_pack_if.slave   bus
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("bm_pack: TIMEOUT out of range");
  end

`ifdef BM_PACK_TIMEOUT_FLUSH_EN
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_FLUSH} state_t;
  logic [15:0] idle_q;
`else
  typedef enum logic [1:0] {S_IDLE, S_FILL} state_t;
`endif

  state_t      state_q;
  logic [1:0]  idx_q;
  logic [31:0] hold_q;
  logic        push_q;
  logic [31:0] push_word_q;
  logic [31:0] placed;

  // Incoming byte shifted into its big-endian lane for the current index.
  assign placed = {bus.byte_data, 24'h0} >> {idx_q, 3'b000};

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= 2'd0;
      hold_q      <= 32'h0;
      push_q      <= 1'b0;
      push_word_q <= 32'h0;
`ifdef BM_PACK_TIMEOUT_FLUSH_EN
      idle_q      <= 16'h0;
`endif
    end else if (clr) begin
      state_q     <= S_IDLE;
      idx_q       <= 2'd0;
      hold_q      <= 32'h0;
      push_q      <= 1'b0;
      push_word_q <= 32'h0;
`ifdef BM_PACK_TIMEOUT_FLUSH_EN
      idle_q      <= 16'h0;
`endif
    end else begin
      push_q <= 1'b0;
`ifdef BM_PACK_TIMEOUT_FLUSH_EN
      if (state_q == S_FLUSH) begin
        push_q      <= 1'b1;
        push_word_q <= hold_q;
        idle_q      <= 16'h0;
        if (bus.byte_vld) begin
          hold_q  <= {bus.byte_data, 24'h0};
          idx_q   <= 2'd1;
          state_q <= S_FILL;
        end else begin
          hold_q  <= 32'h0;
          idx_q   <= 2'd0;
          state_q <= S_IDLE;
        end
      end else
`endif
      if (bus.byte_vld) begin
`ifdef BM_PACK_TIMEOUT_FLUSH_EN
        idle_q <= 16'h0;
`endif
        if (idx_q == 2'd3) begin
          push_q      <= 1'b1;
          push_word_q <= hold_q | placed;
          hold_q      <= 32'h0;
          idx_q       <= 2'd0;
          state_q     <= S_IDLE;
        end else begin
          hold_q  <= hold_q | placed;
          idx_q   <= idx_q + 2'd1;
          state_q <= S_FILL;
        end
      end
`ifdef BM_PACK_TIMEOUT_FLUSH_EN
      else if (state_q == S_FILL) begin
        if (idle_q == TIMEOUT_C) state_q <= S_FLUSH;
        else                     idle_q  <= idle_q + 16'd1;
      end
`endif
    end
  end

  logic [31:0]      mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0] cnt;
  logic [7:0]       ovf_q;
  logic             fifo_full, fifo_empty, pop, wr_en;

  assign cnt        = wr_ptr_q - rd_ptr_q;
  assign fifo_full  = (cnt == DEPTH_C);
  assign fifo_empty = (cnt == '0);
  assign pop        = bus.word_req && !fifo_empty;
  // A push into a full FIFO is only accepted when the head leaves in the same edge.
  assign wr_en      = push_q && (!fifo_full || pop);

  always_ff @(posedge clk_sys) begin
    if (wr_en && !clr) mem[wr_ptr_q[FIFO_AW-1:0]] <= push_word_q;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 8'h0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 8'h0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_q && !wr_en && ovf_q != 8'hFF) ovf_q <= ovf_q + 8'd1;
    end
  end

  assign bus.word_q   = fifo_empty ? 32'h0 : mem[rd_ptr_q[FIFO_AW-1:0]];
  assign bus.word_vld = !fifo_empty;
  assign bus.word_cnt = cnt;
  assign bus.full     = fifo_full;
  assign bus.ovf_cnt  = ovf_q;
endmodule

// File: tb/tb_bm_pack.sv
// tb/tb_bm_pack.sv - directed self-checking bench for bm_pack
module tb_bm_pack;
  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;
  logic clr     = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;

  bm_pack_if #(.FIFO_AW(4)) bus ();

  bm_pack #(.FIFO_AW(4), .TIMEOUT(10)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .clr     (clr),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.byte_data = b;
    bus.byte_vld  = 1'b1;
    tick();
    bus.byte_vld  = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8]);
  endtask

  task automatic pop_one();
    bus.word_req = 1'b1;
    tick();
    bus.word_req = 1'b0;
  endtask

  function automatic logic [31:0] wpat(input int i);
    return 32'h10203040 + 32'(i) * 32'h01010101;
  endfunction

  initial begin
    bus.byte_data = 8'h0;
    bus.byte_vld  = 1'b0;
    bus.word_req  = 1'b0;
    #1;
    chk("rst_word_q",   bus.word_q, 32'h0);
    chk("rst_word_vld", 32'(bus.word_vld), 32'h0);
    chk("rst_word_cnt", 32'(bus.word_cnt), 32'h0);
    chk("rst_full",     32'(bus.full), 32'h0);
    chk("rst_ovf",      32'(bus.ovf_cnt), 32'h0);
    #12 rst_n = 1'b1;
    tick();

    // Basic pack and write latency
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h44);
    chk("lat_vld_early", 32'(bus.word_vld), 32'h0);
    tick();
    chk("lat_vld",  32'(bus.word_vld), 32'h1);
    chk("lat_word", bus.word_q, 32'h11223344);
    chk("lat_cnt",  32'(bus.word_cnt), 32'h1);
    pop_one();
    chk("pop_empty", 32'(bus.word_vld), 32'h0);

    // Reset mid-word discards held bytes
    send_byte(8'h01); send_byte(8'h02);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(bus.word_vld), 32'h0);
    chk("mid_rst_q",   bus.word_q, 32'h0);
    chk("mid_rst_cnt", 32'(bus.word_cnt), 32'h0);
    #4 rst_n = 1'b1;
    tick(); tick();
    chk("mid_rst_nopush", 32'(bus.word_cnt), 32'h0);
    send_word(32'h05060708);
    tick();
    chk("post_rst_word", bus.word_q, 32'h05060708);
    pop_one();

    // Partial word across long idle
    send_byte(8'hAA); send_byte(8'hBB);
    repeat (30) tick();
`ifdef BM_PACK_TIMEOUT_FLUSH_EN
    chk("flush_cnt",  32'(bus.word_cnt), 32'h1);
    chk("flush_word", bus.word_q, 32'hAABB0000);
    pop_one();
    send_byte(8'hCC); send_byte(8'hDD);
    repeat (30) tick();
    chk("flush2_word", bus.word_q, 32'hCCDD0000);
    pop_one();
`else
    chk("hold_cnt", 32'(bus.word_cnt), 32'h0);
    send_byte(8'hCC); send_byte(8'hDD);
    tick();
    chk("hold_word", bus.word_q, 32'hAABBCCDD);
    pop_one();
`endif

    // clr beats byte_vld and word_req in the same cycle
    send_byte(8'h99);
    send_word(32'h01020304);
    tick();
    clr = 1'b1; bus.byte_vld = 1'b1; bus.byte_data = 8'h77; bus.word_req = 1'b1;
    tick();
    clr = 1'b0; bus.byte_vld = 1'b0; bus.word_req = 1'b0;
    chk("clr_cnt", 32'(bus.word_cnt), 32'h0);
    send_word(32'hA1B2C3D4);
    tick();
    chk("clr_word", bus.word_q, 32'hA1B2C3D4);

    // Overflow: 16 fill, 2 dropped
    clr = 1'b1; tick(); clr = 1'b0;
    for (int i = 0; i < 18; i++) send_word(wpat(i));
    tick();
    chk("ovf_full", 32'(bus.full), 32'h1);
    chk("ovf_cnt",  32'(bus.ovf_cnt), 32'h2);
    chk("ovf_wcnt", 32'(bus.word_cnt), 32'h10);
    chk("ovf_head", bus.word_q, wpat(0));

    // Full, push coincides with pop
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_ovf", 32'(bus.ovf_cnt), 32'h0);
    for (int i = 0; i < 16; i++) send_word(wpat(i));
    tick();
    chk("pp_full_before", 32'(bus.full), 32'h1);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    bus.word_req = 1'b1;
    tick();
    chk("pp_cnt", 32'(bus.word_cnt), 32'h10);
    chk("pp_ovf", 32'(bus.ovf_cnt), 32'h0);
    for (int i = 1; i < 17; i++) begin
      chk($sformatf("order%0d", i), bus.word_q, (i == 16) ? 32'hDEADBEEF : wpat(i));
      tick();
    end
    // word_req still high for 3 extra cycles on an empty FIFO
    repeat (3) tick();
    bus.word_req = 1'b0;
    chk("drain_vld", 32'(bus.word_vld), 32'h0);
    chk("drain_q",   bus.word_q, 32'h0);
    chk("drain_cnt", 32'(bus.word_cnt), 32'h0);
    chk("drain_rd",  32'(dut.rd_ptr_q), 32'd17);
    chk("drain_wr",  32'(dut.wr_ptr_q), 32'd17);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
